// File: rtl/bip_pkg.sv
// Shared types and constants for the BIP-2 instruction-memory loader.
package bip_pkg;
  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 16;

  // Opcode field is instr[15:11]; an all-zero word decodes as HLT.
  localparam logic [4:0] OPC_HLT  = 5'd0;
  localparam logic [4:0] OPC_LDI  = 5'd3;
  localparam logic [4:0] OPC_SUBI = 5'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2,
    ST_RUN   = 2'd3
  } state_e;
endpackage

// File: rtl/bip_imem_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port, no reset.
module bip_imem_ram #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [1<<ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/bip_imem_loader.sv
// Program loader + instruction-fetch responder for the BIP-2 control unit.
// Define BIP_IMEM_CHECKSUM_EN to require a 16-bit sum trailer after each program.
module bip_imem_loader
  import bip_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              Clock_i,
  input  logic              Rst_n_i,
  input  logic              Load_start_i,
  input  logic [ADDR_W-1:0] Load_len_i,
  input  logic [DATA_W-1:0] Load_data_i,
  input  logic              Load_valid_i,
  output logic              Load_ready_o,
  output logic              Load_done_o,
  output logic              Cpu_run_o,
  input  logic [ADDR_W-1:0] ADDR_im_i,
  output logic [DATA_W-1:0] DATA_im_o,
  output logic              Chk_err_o
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              ready_q, done_q, run_q, rd_vld_q;
  logic              done_d, we;
  logic              accept;
  logic [DATA_W-1:0] rdata;
`ifdef BIP_IMEM_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              err_q, err_d;
`endif

  assign accept = Load_valid_i && ready_q;

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    last_d  = last_q;
    done_d  = 1'b0;
    we      = 1'b0;
`ifdef BIP_IMEM_CHECKSUM_EN
    sum_d   = sum_q;
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (Load_start_i) begin
          last_d  = Load_len_i;
          wptr_d  = '0;
          state_d = ST_LOAD;
`ifdef BIP_IMEM_CHECKSUM_EN
          sum_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      ST_LOAD: begin
        if (accept) begin
          we     = 1'b1;
          wptr_d = wptr_q + 1'b1;
`ifdef BIP_IMEM_CHECKSUM_EN
          sum_d  = sum_q + Load_data_i;
          if (wptr_q == last_q) state_d = ST_CHECK;
`else
          if (wptr_q == last_q) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
          end
`endif
        end
      end
`ifdef BIP_IMEM_CHECKSUM_EN
      // Trailer word: compared against the sum, never written to RAM.
      ST_CHECK: begin
        if (accept) begin
          done_d = 1'b1;
          if (Load_data_i == sum_q) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      state_q  <= ST_IDLE;
      wptr_q   <= '0;
      last_q   <= '0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      run_q    <= 1'b0;
      rd_vld_q <= 1'b0;
`ifdef BIP_IMEM_CHECKSUM_EN
      sum_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      last_q   <= last_d;
      ready_q  <= (state_d == ST_LOAD) || (state_d == ST_CHECK);
      done_q   <= done_d;
      run_q    <= (state_d == ST_RUN);
      // Read data is trustworthy only if the previous cycle issued a RUN read.
      rd_vld_q <= (state_q == ST_RUN);
`ifdef BIP_IMEM_CHECKSUM_EN
      sum_q    <= sum_d;
      err_q    <= err_d;
`endif
    end
  end

  bip_imem_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk_i   (Clock_i),
    .we_i    (we),
    .waddr_i (wptr_q),
    .wdata_i (Load_data_i),
    .re_i    (state_q == ST_RUN),
    .raddr_i (ADDR_im_i),
    .rdata_o (rdata)
  );

  assign Load_ready_o = ready_q;
  assign Load_done_o  = done_q;
  assign Cpu_run_o    = run_q;
  // Anything but a valid RUN fetch reads as HLT so the control unit stops.
  assign DATA_im_o    = (run_q && rd_vld_q) ? rdata : {OPC_HLT, {(DATA_W-5){1'b0}}};
`ifdef BIP_IMEM_CHECKSUM_EN
  assign Chk_err_o    = err_q;
`else
  assign Chk_err_o    = 1'b0;
`endif
endmodule

// File: tb/tb_bip_imem_loader.sv
// Directed bench for bip_imem_loader with a fetch-result scoreboard queue.
module tb_bip_imem_loader;
  localparam int AW = 11;
  localparam int DW = 16;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          Load_start_i;
  logic [AW-1:0] Load_len_i;
  logic [DW-1:0] Load_data_i;
  logic          Load_valid_i;
  logic          Load_ready_o, Load_done_o, Cpu_run_o, Chk_err_o;
  logic [AW-1:0] ADDR_im_i;
  logic [DW-1:0] DATA_im_o;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] wbuf  [DEPTH];
  logic [DW-1:0] sb_q [$];

  bip_imem_loader dut (
    .Clock_i(clk), .Rst_n_i(rst_n),
    .Load_start_i(Load_start_i), .Load_len_i(Load_len_i),
    .Load_data_i(Load_data_i), .Load_valid_i(Load_valid_i),
    .Load_ready_o(Load_ready_o), .Load_done_o(Load_done_o),
    .Cpu_run_o(Cpu_run_o), .ADDR_im_i(ADDR_im_i), .DATA_im_o(DATA_im_o),
    .Chk_err_o(Chk_err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Streams wbuf[0..n-1] (plus the checksum trailer when enabled) and checks handshake.
  task automatic do_load(input int n, input bit toggle, input bit bad_tr);
    int tot, acc, cyc;
    logic [DW-1:0] sum;
    logic rdy;
    sum = '0;
    for (int i = 0; i < n; i++) sum = sum + wbuf[i];
    tot = n;
`ifdef BIP_IMEM_CHECKSUM_EN
    tot = n + 1;
`endif
    Load_start_i = 1'b1;
    Load_len_i   = AW'(n - 1);
    tick();
    Load_start_i = 1'b0;
    chk("ready_first_load_cycle", Load_ready_o, 1'b1);
    acc = 0;
    cyc = 0;
    while (acc < tot && cyc < 3 * tot + 10) begin
      Load_valid_i = toggle ? (cyc % 2 == 0) : 1'b1;
      Load_data_i  = (acc < n) ? wbuf[acc] : (bad_tr ? sum + 16'd1 : sum);
      rdy = Load_ready_o;
      tick();
      cyc++;
      if (Load_valid_i && rdy) begin
        if (acc < n) model[acc] = wbuf[acc];
        acc++;
        if (acc >= tot - 1 || toggle) chk("done_vs_accepts", Load_done_o, acc == tot);
      end else if (toggle) begin
        chk("done_idle_cycle", Load_done_o, 1'b0);
      end
    end
    Load_valid_i = 1'b0;
    chk("accept_count", acc, tot);
    chk("run_after_load", Cpu_run_o, !bad_tr);
    chk("ready_drops", Load_ready_o, 1'b0);
    tick();
    chk("done_single_pulse", Load_done_o, 1'b0);
`ifdef BIP_IMEM_CHECKSUM_EN
    chk("chk_err", Chk_err_o, bad_tr);
`endif
  endtask

  task automatic fetch(input logic [AW-1:0] a);
    logic [DW-1:0] exp;
    ADDR_im_i = a;
    sb_q.push_back(model[a]);
    tick();
    exp = sb_q.pop_front();
    chk("fetch_data", DATA_im_o, exp);
  endtask

  initial begin
    rst_n = 1'b0; Load_start_i = 1'b0; Load_len_i = '0; Load_data_i = '0;
    Load_valid_i = 1'b0; ADDR_im_i = '0;
    repeat (2) tick();
    rst_n = 1'b1;

    // 1: reset state, no program loaded
    ADDR_im_i = 11'd2;
    tick();
    chk("rst_data", DATA_im_o, 16'h0000);
    chk("rst_run", Cpu_run_o, 1'b0);
    chk("rst_ready", Load_ready_o, 1'b0);
    chk("rst_done", Load_done_o, 1'b0);
    chk("rst_err", Chk_err_o, 1'b0);

    // 2: three-word program, then fetch it back
    wbuf[0] = 16'h1802; wbuf[1] = 16'h3801; wbuf[2] = 16'h47FF;
    do_load(3, 1'b0, 1'b0);
    fetch(11'd0); fetch(11'd1); fetch(11'd2);

    // 3: bursty valid, four words
    for (int i = 0; i < 4; i++) wbuf[i] = 16'hC000 + 16'(i * 3);
    do_load(4, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) fetch(AW'(i));

    // 4: full-depth load, last word and no wrap onto word 0
    for (int i = 0; i < DEPTH; i++) wbuf[i] = 16'(i) ^ 16'h5A00;
    do_load(DEPTH, 1'b0, 1'b0);
    fetch(11'h7FF); fetch(11'h000); fetch(11'h400);

    // 5: asynchronous reset after the first word of three
    for (int i = 0; i < 3; i++) wbuf[i] = 16'h2100 + 16'(i);
    Load_start_i = 1'b1; Load_len_i = 11'd2;
    tick();
    Load_start_i = 1'b0;
    Load_valid_i = 1'b1; Load_data_i = wbuf[0];
    tick();
    model[0] = wbuf[0];
    Load_valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_run", Cpu_run_o, 1'b0);
    chk("midrst_ready", Load_ready_o, 1'b0);
    chk("midrst_data", DATA_im_o, 16'h0000);
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_idle_ready", Load_ready_o, 1'b0);
    do_load(3, 1'b0, 1'b0);
    fetch(11'd0); fetch(11'd1); fetch(11'd2); fetch(11'd3);

`ifdef BIP_IMEM_CHECKSUM_EN
    // 6: checksum trailer match, then mismatch
    wbuf[0] = 16'd1; wbuf[1] = 16'd2; wbuf[2] = 16'd3;
    do_load(3, 1'b0, 1'b0);
    fetch(11'd2);
    do_load(3, 1'b0, 1'b1);
    ADDR_im_i = 11'd1;
    tick();
    chk("chkerr_halt_data", DATA_im_o, 16'h0000);
    chk("chkerr_sticky", Chk_err_o, 1'b1);
    chk("chkerr_norun", Cpu_run_o, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
